memory_stage: RTL and testbench

//  M stage of the 5-stage RV32I pipeline; producer side of the M->W interface.

---
 rtl/memory_pkg.sv | 45 ++++
 rtl/load_align.sv | 35 +++
 rtl/memory_stage.sv | 164 ++++++++++++++++
 tb/tb_memory_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and constants for the M stage: FSM states, funct3 codes, byte-enable patterns,
// and the access-alignment rule.
package memory_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRsp  = 2'd2,
        StDone = 2'd3
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // Stores decode only B/H as narrow; loads also treat BU/HU as narrow. Everything else is a word.
    function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic mis;
        mis = (off != 2'b00);
        if (is_store) begin
            if (f3 == F3_B) begin
                mis = 1'b0;
            end else if (f3 == F3_H) begin
                mis = off[0];
            end
        end else begin
            if (f3 == F3_B || f3 == F3_BU) begin
                mis = 1'b0;
            end else if (f3 == F3_H || f3 == F3_HU) begin
                mis = off[0];
            end
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte/halfword of a bus word and sign- or
// zero-extends it according to funct3.
module load_align
    import memory_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// M stage of the RV32I pipeline: registers E results, runs loads/stores over a valid/ready bus
// and stalls upstream until the access completes.
module memory_stage
    import memory_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned BUS_ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [XLEN-1:0]       alu_result_e_i,
    input  logic [XLEN-1:0]       write_data_e_i,
    input  logic [4:0]            rd_e_i,
    input  logic [XLEN-1:0]       pc_plus_4_e_i,
    input  logic                  mem_read_e_i,
    input  logic                  mem_write_e_i,
    input  logic [2:0]            funct3_e_i,
    output logic [XLEN-1:0]       alu_result_m_o,
    output logic [XLEN-1:0]       read_data_m_o,
    output logic [4:0]            rd_m_o,
    output logic [XLEN-1:0]       pc_plus_4_m_o,
    output logic                  stall_o,
    output logic                  misaligned_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic                  req_we_o,
    output logic [BUS_ADDR_W-1:0] req_addr_o,
    output logic [XLEN-1:0]       req_wdata_o,
    output logic [3:0]            req_be_o,
    input  logic                  rsp_valid_i,
    input  logic [XLEN-1:0]       rsp_rdata_i
);

    if (XLEN != 32) begin : g_xlen_check
        $error("memory_stage: only XLEN=32 is supported");
    end
    if (BUS_ADDR_W < 3 || BUS_ADDR_W > XLEN) begin : g_addr_w_check
        $error("memory_stage: BUS_ADDR_W must be in [3, XLEN]");
    end

    mem_state_e      state_q, state_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] alu_q, wdata_q, pc4_q, rdata_q;
    logic [4:0]      rd_q;
    logic            we_q;
    logic [2:0]      f3_q;

    logic            stall, capture;
    logic            is_mem_e, is_store_e, mis_e;
    logic [XLEN-1:0] load_data, st_wdata;
    logic [3:0]      st_be;

    assign stall      = (state_q == StReq) || (state_q == StRsp);
    assign capture    = ~stall;
    assign is_mem_e   = mem_read_e_i | mem_write_e_i;
    // Read wins when both flags are set.
    assign is_store_e = mem_write_e_i & ~mem_read_e_i;
    assign mis_e      = is_misaligned(is_store_e, funct3_e_i, alu_result_e_i[1:0]);

    always_comb begin
        state_d = state_q;
        mis_d   = mis_q;
        unique case (state_q)
            StIdle, StDone: begin
                mis_d = is_mem_e & mis_e;
                if (!is_mem_e) begin
                    state_d = StIdle;
                end else if (mis_e) begin
                    state_d = StDone;
                end else begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (req_ready_i) begin
                    state_d = we_q ? StDone : StRsp;
                end
            end
            StRsp: begin
                if (rsp_valid_i) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            alu_q   <= '0;
            wdata_q <= '0;
            pc4_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
        end else if (capture) begin
            alu_q   <= alu_result_e_i;
            wdata_q <= write_data_e_i;
            pc4_q   <= pc_plus_4_e_i;
            rd_q    <= rd_e_i;
            we_q    <= is_store_e;
            f3_q    <= funct3_e_i;
        end
    end

    load_align u_load_align (
        .word_i   (rsp_rdata_i),
        .offset_i (alu_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    // Cleared on every capture so only a completed load ever presents data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= '0;
        end else if (state_q == StRsp && rsp_valid_i) begin
            rdata_q <= load_data;
        end
    end

    always_comb begin
        case (f3_q)
            F3_B: begin
                st_wdata = {4{wdata_q[7:0]}};
                st_be    = BE_B0 << alu_q[1:0];
            end
            F3_H: begin
                st_wdata = {2{wdata_q[15:0]}};
                st_be    = alu_q[1] ? BE_HI : BE_LO;
            end
            default: begin
                st_wdata = wdata_q;
                st_be    = BE_ALL;
            end
        endcase
    end

    assign req_valid_o  = (state_q == StReq);
    assign req_we_o     = req_valid_o & we_q;
    assign req_addr_o   = req_valid_o ? {alu_q[BUS_ADDR_W-1:2], 2'b00} : '0;
    assign req_wdata_o  = req_we_o ? st_wdata : '0;
    assign req_be_o     = req_we_o ? st_be : (req_valid_o ? BE_ALL : BE_NONE);

    assign stall_o        = stall;
    assign misaligned_o   = (state_q == StDone) & mis_q;
    assign rd_m_o         = ((state_q == StIdle) || (state_q == StDone && !mis_q)) ? rd_q : 5'd0;
    assign alu_result_m_o = alu_q;
    assign pc_plus_4_m_o  = pc4_q;
    assign read_data_m_o  = rdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, a mid-transaction reset
// sequence, and randomized instructions checked against a byte-level reference model.
module tb_memory_stage;

    logic        clk_i, reset_i;
    logic [31:0] alu_result_e_i, write_data_e_i, pc_plus_4_e_i;
    logic [4:0]  rd_e_i;
    logic        mem_read_e_i, mem_write_e_i;
    logic [2:0]  funct3_e_i;
    logic [31:0] alu_result_m_o, read_data_m_o, pc_plus_4_m_o;
    logic [4:0]  rd_m_o;
    logic        stall_o, misaligned_o, req_valid_o, req_ready_i, req_we_o;
    logic [31:0] req_addr_o, req_wdata_o;
    logic [3:0]  req_be_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_rdata_i;

    memory_stage dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alu_result_e_i (alu_result_e_i),
        .write_data_e_i (write_data_e_i),
        .rd_e_i         (rd_e_i),
        .pc_plus_4_e_i  (pc_plus_4_e_i),
        .mem_read_e_i   (mem_read_e_i),
        .mem_write_e_i  (mem_write_e_i),
        .funct3_e_i     (funct3_e_i),
        .alu_result_m_o (alu_result_m_o),
        .read_data_m_o  (read_data_m_o),
        .rd_m_o         (rd_m_o),
        .pc_plus_4_m_o  (pc_plus_4_m_o),
        .stall_o        (stall_o),
        .misaligned_o   (misaligned_o),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_we_o       (req_we_o),
        .req_addr_o     (req_addr_o),
        .req_wdata_o    (req_wdata_o),
        .req_be_o       (req_be_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_rdata_i    (rsp_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rd_en;
        bit          wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc;
        int          rdy_dly;
        int          rsp_dly;
    } op_t;

    typedef struct {
        bit          mem;
        bit          we;
        bit          mis;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Reference: access size from funct3, bytes covered = [off, off+size), data replicated by size.
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          sz, off;
        logic [63:0] v;
        e = '{default: 0};
        e.mem = op.rd_en || op.wr_en;
        e.we  = op.wr_en && !op.rd_en;
        if (!e.mem) return e;
        if (e.we) sz = (op.f3 == 0) ? 1 : (op.f3 == 1) ? 2 : 4;
        else      sz = (op.f3 == 0 || op.f3 == 4) ? 1 : (op.f3 == 1 || op.f3 == 5) ? 2 : 4;
        off     = int'(op.addr % 4);
        e.mis   = (off % sz) != 0;
        e.baddr = op.addr - 32'(off);
        for (int i = 0; i < 4; i++) begin
            e.be[i]           = (i >= off) && (i < off + sz);
            e.bwdata[8*i +: 8] = op.wd[8*(i % sz) +: 8];
        end
        v = 64'(op.rdata) >> (8 * off);
        if (sz < 4) begin
            v = v % (64'd1 << (8 * sz));
            if (op.f3 < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        end
        e.rdata = e.mis ? 32'h0 : v[31:0];
        return e;
    endfunction

    function automatic op_t mk_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rdata, input logic [4:0] rd,
                                  input int rdy, input int rsp);
        op_t o;
        o = '{rd_en: rd_en, wr_en: wr_en, f3: f3, addr: addr, wd: wd, rdata: rdata, rd: rd,
              pc: addr + 32'h4000, rdy_dly: rdy, rsp_dly: rsp};
        return o;
    endfunction

    function automatic exp_t mk_ex(input bit mem, input bit we, input bit mis,
                                   input logic [31:0] baddr, input logic [31:0] bwdata,
                                   input logic [3:0] be, input logic [31:0] rdata);
        exp_t e;
        e = '{mem: mem, we: we, mis: mis, baddr: baddr, bwdata: bwdata, be: be, rdata: rdata};
        return e;
    endfunction

    task automatic bubble();
        alu_result_e_i = $urandom;
        write_data_e_i = $urandom;
        pc_plus_4_e_i  = $urandom;
        rd_e_i         = 5'($urandom);
        funct3_e_i     = 3'($urandom);
        mem_read_e_i   = 1'b0;
        mem_write_e_i  = 1'b0;
    endtask

    // Called at a negedge with stall low; returns at the negedge where the result commits.
    task automatic exec(input op_t op, input exp_t ex, input string tag);
        alu_result_e_i = op.addr;
        write_data_e_i = op.wd;
        pc_plus_4_e_i  = op.pc;
        rd_e_i         = op.rd;
        funct3_e_i     = op.f3;
        mem_read_e_i   = op.rd_en;
        mem_write_e_i  = op.wr_en;
        @(negedge clk_i);
        bubble();
        if (ex.mem && !ex.mis) begin
            for (int c = 0; c <= op.rdy_dly; c++) begin
                check({tag, ".req_valid"}, 32'(req_valid_o), 32'd1);
                check({tag, ".req_stall"}, 32'(stall_o), 32'd1);
                check({tag, ".req_rd"}, 32'(rd_m_o), 32'd0);
                check({tag, ".req_addr"}, req_addr_o, ex.baddr);
                check({tag, ".req_we"}, 32'(req_we_o), 32'(ex.we));
                check({tag, ".req_hold"}, alu_result_m_o, op.addr);
                if (ex.we) begin
                    check({tag, ".req_wdata"}, req_wdata_o, ex.bwdata);
                    check({tag, ".req_be"}, 32'(req_be_o), 32'(ex.be));
                end
                req_ready_i = (c == op.rdy_dly);
                rsp_valid_i = 1'($urandom);
                rsp_rdata_i = $urandom;
                @(negedge clk_i);
                bubble();
            end
            req_ready_i = 1'b0;
            rsp_valid_i = 1'b0;
            if (!ex.we) begin
                for (int c = 0; c <= op.rsp_dly; c++) begin
                    check({tag, ".rsp_valid"}, 32'(req_valid_o), 32'd0);
                    check({tag, ".rsp_stall"}, 32'(stall_o), 32'd1);
                    check({tag, ".rsp_rd"}, 32'(rd_m_o), 32'd0);
                    rsp_valid_i = (c == op.rsp_dly);
                    rsp_rdata_i = (c == op.rsp_dly) ? op.rdata : $urandom;
                    @(negedge clk_i);
                    bubble();
                end
                rsp_valid_i = 1'b0;
            end
        end
        check({tag, ".stall"}, 32'(stall_o), 32'd0);
        check({tag, ".req_valid_end"}, 32'(req_valid_o), 32'd0);
        check({tag, ".misaligned"}, 32'(misaligned_o), 32'(ex.mis));
        check({tag, ".rd"}, 32'(rd_m_o), ex.mis ? 32'd0 : 32'(op.rd));
        check({tag, ".alu"}, alu_result_m_o, op.addr);
        check({tag, ".pc4"}, pc_plus_4_m_o, op.pc);
        if (ex.mis || (ex.mem && !ex.we)) check({tag, ".rdata"}, read_data_m_o, ex.rdata);
    endtask

    vec_t vec[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_t op;
        int  k;
        reset_i        = 1'b1;
        req_ready_i    = 1'b0;
        rsp_valid_i    = 1'b0;
        rsp_rdata_i    = '0;
        alu_result_e_i = '0;
        write_data_e_i = '0;
        pc_plus_4_e_i  = '0;
        rd_e_i         = '0;
        funct3_e_i     = '0;
        mem_read_e_i   = 1'b0;
        mem_write_e_i  = 1'b0;

        vec[0]  = '{mk_op(0, 0, 3'd0, 32'h1234, 32'h0, 32'h0, 5'd5, 0, 0),
                    mk_ex(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0)};
        vec[1]  = '{mk_op(0, 1, 3'd0, 32'h103, 32'h1234_56AB, 32'h0, 5'd9, 0, 0),
                    mk_ex(1, 1, 0, 32'h100, 32'hABAB_ABAB, 4'b1000, 32'h0)};
        vec[2]  = '{mk_op(1, 0, 3'd1, 32'h202, 32'h0, 32'h8001_7FFF, 5'd10, 2, 0),
                    mk_ex(1, 0, 0, 32'h200, 32'h0, 4'h0, 32'hFFFF_8001)};
        vec[3]  = '{mk_op(1, 0, 3'd4, 32'h301, 32'h0, 32'h0000_F000, 5'd11, 0, 1),
                    mk_ex(1, 0, 0, 32'h300, 32'h0, 4'h0, 32'h0000_00F0)};
        vec[4]  = '{mk_op(1, 0, 3'd2, 32'h402, 32'h0, 32'h0, 5'd12, 0, 0),
                    mk_ex(1, 0, 1, 32'h400, 32'h0, 4'h0, 32'h0)};
        vec[5]  = '{mk_op(0, 1, 3'd1, 32'h12, 32'h1234_BEEF, 32'h0, 5'd13, 1, 0),
                    mk_ex(1, 1, 0, 32'h10, 32'hBEEF_BEEF, 4'b1100, 32'h0)};
        vec[6]  = '{mk_op(0, 1, 3'd3, 32'h20, 32'hDEAD_BEEF, 32'h0, 5'd14, 0, 0),
                    mk_ex(1, 1, 0, 32'h20, 32'hDEAD_BEEF, 4'b1111, 32'h0)};
        vec[7]  = '{mk_op(1, 0, 3'd0, 32'h3, 32'h0, 32'h8012_3456, 5'd15, 0, 2),
                    mk_ex(1, 0, 0, 32'h0, 32'h0, 4'h0, 32'hFFFF_FF80)};
        vec[8]  = '{mk_op(1, 1, 3'd5, 32'h0, 32'hFFFF_FFFF, 32'h1234_FFFF, 5'd16, 1, 1),
                    mk_ex(1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_FFFF)};
        vec[9]  = '{mk_op(0, 1, 3'd1, 32'h5, 32'h55, 32'h0, 5'd17, 0, 0),
                    mk_ex(1, 1, 1, 32'h4, 32'h0, 4'h0, 32'h0)};
        vec[10] = '{mk_op(1, 0, 3'd7, 32'h8, 32'h0, 32'hCAFE_F00D, 5'd18, 0, 0),
                    mk_ex(1, 0, 0, 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D)};
        vec[11] = '{mk_op(0, 1, 3'd0, 32'h4, 32'hFFFF_FF7F, 32'h0, 5'd19, 0, 0),
                    mk_ex(1, 1, 0, 32'h4, 32'h7F7F_7F7F, 4'b0001, 32'h0)};

        @(negedge clk_i);
        @(negedge clk_i);
        check("reset.alu", alu_result_m_o, 32'h0);
        check("reset.rdata", read_data_m_o, 32'h0);
        check("reset.rd", 32'(rd_m_o), 32'h0);
        check("reset.pc4", pc_plus_4_m_o, 32'h0);
        check("reset.stall", 32'(stall_o), 32'h0);
        check("reset.req_valid", 32'(req_valid_o), 32'h0);
        check("reset.misaligned", 32'(misaligned_o), 32'h0);
        reset_i = 1'b0;

        for (int i = 0; i < 12; i++) exec(vec[i].op, vec[i].ex, $sformatf("vec%0d", i));

        // Reset while a load waits in REQ; a response arriving afterwards must be ignored.
        alu_result_e_i = 32'h40;
        rd_e_i         = 5'd21;
        funct3_e_i     = 3'd2;
        mem_read_e_i   = 1'b1;
        mem_write_e_i  = 1'b0;
        @(negedge clk_i);
        bubble();
        check("midrst.req_before", 32'(req_valid_o), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        check("midrst.req_valid", 32'(req_valid_o), 32'd0);
        check("midrst.stall", 32'(stall_o), 32'd0);
        check("midrst.rd", 32'(rd_m_o), 32'd0);
        check("midrst.alu", alu_result_m_o, 32'd0);
        @(negedge clk_i);
        alu_result_e_i = '0;
        rd_e_i         = '0;
        mem_read_e_i   = 1'b0;
        rsp_valid_i    = 1'b1;
        rsp_rdata_i    = 32'hDEAD_BEEF;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        check("midrst.post_req_valid", 32'(req_valid_o), 32'd0);
        check("midrst.post_stall", 32'(stall_o), 32'd0);
        check("midrst.post_rd", 32'(rd_m_o), 32'd0);
        check("midrst.post_rdata", read_data_m_o, 32'd0);

        for (int i = 0; i < 200; i++) begin
            k          = $urandom_range(0, 3);
            op.rd_en   = (k == 1) || (k == 3);
            op.wr_en   = (k == 2) || (k == 3);
            op.f3      = 3'($urandom_range(0, 7));
            op.addr    = $urandom;
            op.wd      = $urandom;
            op.rdata   = $urandom;
            op.rd      = 5'($urandom_range(0, 31));
            op.pc      = $urandom;
            op.rdy_dly = $urandom_range(0, 3);
            op.rsp_dly = $urandom_range(0, 3);
            exec(op, model(op), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
